// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the EX-stage ALUs and the decoder.
//   - MIPS funct-code constants (6 bits)
//   - FSM state encoding for the multi-cycle ALU (IDLE/RUN)
//   - is_multicycle(): true for the ops that iterate (MULTU, DIVU)
package alu_pkg;

   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } alu_state_e;

   function automatic logic is_multicycle(input logic [5:0] funct);
      return (funct == FN_MULTU) || (funct == FN_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle unsigned multiply (shift-add) and divide
// (restoring). hi_o/lo_o show the result of the step taken on the current
// edge, so the final step's result can be captured on the same edge it is
// computed.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_i         capture operands, clear counter
//   step_i         perform one iteration
//   op_is_div_i    0 = MULTU, 1 = DIVU (sampled with load_i)
//   a_i, b_i       operands (multiplier/dividend, multiplicand/divisor)
//   hi_o, lo_o     post-step high/low halves (product or remainder/quotient)
//   last_o         the current step is the final one
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             op_is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             last_o
);

   localparam int CW = $clog2(WIDTH);

   // acc: partial product high half / partial remainder
   // quo: multiplier being consumed LSB-first / dividend shifted out MSB-first
   //      while quotient bits shift in at the bottom
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] opnd_q;
   logic [CW-1:0]    cnt_q;
   logic             div_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      sum     = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
      shifted = {acc_q, quo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, opnd_q});
      // When the divisor fits, the difference is below the divisor, so the
      // truncated subtraction is exact.
      diff    = shifted[WIDTH-1:0] - opnd_q;
      if (div_q) begin
         acc_d = fits ? diff : shifted[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], fits};
      end else begin
         acc_d = sum[WIDTH:1];
         quo_d = {sum[0], quo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         quo_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
      end else if (load_i) begin
         acc_q  <= '0;
         quo_q  <= a_i;
         opnd_q <= b_i;
         cnt_q  <= '0;
         div_q  <= op_is_div_i;
      end else if (step_i) begin
         acc_q  <= acc_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign hi_o   = acc_d;
   assign lo_o   = quo_d;
   assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle EX-stage ALU. Single-cycle ops (AND, OR, ADD, SUB,
// SLT, SRL, MFHI, MFLO, unknown->0) register their result one cycle after
// start. MULTU/DIVU iterate WIDTH cycles in muldiv_iter and write HI/LO.
// Handshake: start is sampled only while busy=0; start while busy=1 is
// dropped. done pulses for one cycle whenever dataOut or HI/LO is written.
// Ports:
//   clk, rst        clock, synchronous active-high reset (wins over start)
//   start           issue strobe
//   Signal          MIPS funct code
//   dataA, dataB    operands; shift amount is dataB[log2(WIDTH)-1:0]
//   dataOut         registered result
//   busy            high while MULTU/DIVU iterate
//   done            one-cycle completion pulse
//   dbg_state       current FSM state
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done,
   output alu_state_e       dbg_state
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic             it_load, it_step, it_last;
   logic [WIDTH-1:0] it_hi, it_lo;
   logic [WIDTH-1:0] alu_res;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk         (clk),
      .rst         (rst),
      .load_i      (it_load),
      .step_i      (it_step),
      .op_is_div_i (Signal == FN_DIVU),
      .a_i         (dataA),
      .b_i         (dataB),
      .hi_o        (it_hi),
      .lo_o        (it_lo),
      .last_o      (it_last)
   );

   always_comb begin
      case (Signal)
         FN_AND:  alu_res = dataA & dataB;
         FN_OR:   alu_res = dataA | dataB;
         FN_ADD:  alu_res = dataA + dataB;
         FN_SUB:  alu_res = dataA - dataB;
         FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
         FN_SRL:  alu_res = dataA >> dataB[SHW-1:0];
         FN_MFHI: alu_res = hi_q;
         FN_MFLO: alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      it_load = 1'b0;
      it_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_multicycle(Signal)) begin
                  it_load = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  dout_d  = alu_res;
                  done_d  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            it_step = 1'b1;
            if (it_last) begin
               // The final iteration's result is written straight into HI/LO.
               hi_d    = it_hi;
               lo_d    = it_lo;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dout_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign dataOut   = dout_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [5:0]   Signal;
   logic [W-1:0] dataA, dataB;
   logic [W-1:0] dataOut;
   logic         busy, done;
   alu_state_e   dbg_state;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .Signal    (Signal),
      .dataA     (dataA),
      .dataB     (dataB),
      .dataOut   (dataOut),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state kept at the architectural level
   logic [W-1:0] model_hi, model_lo, model_dout;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_single(input logic [5:0] f, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint s;
      int     sa, sb;
      sa = a;
      sb = b;
      case (f)
         FN_AND:  return a & b;
         FN_OR:   return a | b;
         FN_ADD:  begin s = longint'(a) + longint'(b); return s[W-1:0]; end
         FN_SUB:  begin s = longint'(a) - longint'(b); return s[W-1:0]; end
         FN_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
         FN_SRL:  return a / (32'd1 << (b % 32));
         FN_MFHI: return model_hi;
         FN_MFLO: return model_lo;
         default: return '0;
      endcase
   endfunction

   task automatic ref_muldiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned p;
      if (f == FN_MULTU) begin
         p = longint'(a) * longint'(b);
         model_hi = p[63:32];
         model_lo = p[31:0];
      end else if (b == 0) begin
         model_lo = '1;
         model_hi = a;
      end else begin
         model_lo = a / b;
         model_hi = a % b;
      end
   endtask

   // driver: single-cycle op, issued at a negedge, checked one cycle later
   task automatic issue(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      exp_q.push_back(ref_single(f, a, b));
      start = 1'b1; Signal = f; dataA = a; dataB = b;
      @(negedge clk);
      start = 1'b0;
      model_dout = exp_q.pop_front();
      check({tag, "_done"}, W'(done), W'(1));
      check({tag, "_busy"}, W'(busy), W'(0));
      check(tag, dataOut, model_dout);
   endtask

   // driver: MULTU/DIVU; optional ignored ADD injected at busy cycle inj.
   // Returns at the negedge of the done cycle.
   task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int inj);
      int n;
      start = 1'b1; Signal = f; dataA = a; dataB = b;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         check({tag, "_done_low"}, W'(done), W'(0));
         check({tag, "_dout_hold"}, dataOut, model_dout);
         if (n == inj) begin
            start = 1'b1; Signal = FN_ADD; dataA = 32'h11; dataB = 32'h22;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_busy_cycles"}, W'(n), W'(W));
      check({tag, "_done"}, W'(done), W'(1));
      check({tag, "_dout_after"}, dataOut, model_dout);
      ref_muldiv(f, a, b);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "_done_idle"}, W'(done), W'(0));
   endtask

   logic [5:0] fn_tab[10] = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL,
                              FN_MFHI, FN_MFLO, 6'b111111, 6'b000000};

   initial begin
      int n;
      logic [W-1:0] ra, rb;
      rst = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
      model_hi = '0; model_lo = '0; model_dout = '0;
      repeat (2) @(negedge clk);
      check("rst_dout", dataOut, '0);
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      rst = 1'b0;
      @(negedge clk);

      // directed single-cycle ops
      issue("add_ovf", FN_ADD, 32'h7FFFFFFF, 32'h00000001);
      check("add_ovf_val", dataOut, 32'h80000000);
      idle_check("add_ovf");
      issue("sub", FN_SUB, 32'd5, 32'd7);
      issue("and", FN_AND, 32'hF0F0F0F0, 32'hFF00FF00);
      issue("or",  FN_OR,  32'hF0F0F0F0, 32'hFF00FF00);
      issue("slt_neg", FN_SLT, 32'hFFFFFFFF, 32'h00000001);
      issue("slt_pos", FN_SLT, 32'h00000001, 32'hFFFFFFFF);
      issue("srl31", FN_SRL, 32'h80000000, 32'd31);
      issue("unknown", 6'b111111, 32'h1234, 32'h5678);
      issue("mfhi_rst", FN_MFHI, '0, '0);
      issue("mflo_rst", FN_MFLO, '0, '0);

      // MULTU max*max, MFHI issued in the done cycle
      run_md("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      issue("multu_hi", FN_MFHI, '0, '0);
      check("multu_hi_val", dataOut, 32'hFFFFFFFE);
      issue("multu_lo", FN_MFLO, '0, '0);
      check("multu_lo_val", dataOut, 32'h00000001);

      // DIVU
      run_md("divu_100_7", FN_DIVU, 32'd100, 32'd7, 0);
      idle_check("divu_100_7");
      issue("divu_lo", FN_MFLO, '0, '0);
      issue("divu_hi", FN_MFHI, '0, '0);
      run_md("divu_by0", FN_DIVU, 32'h12345678, 32'd0, 0);
      issue("divu0_lo", FN_MFLO, '0, '0);
      check("divu0_lo_val", dataOut, 32'hFFFFFFFF);
      issue("divu0_hi", FN_MFHI, '0, '0);
      check("divu0_hi_val", dataOut, 32'h12345678);

      // ADD at busy cycle 5 is dropped; MFLO in the done cycle sees new LO
      issue("pre_add", FN_ADD, 32'd40, 32'd2);
      run_md("multu_inj", FN_MULTU, 32'h0001_0003, 32'h0002_0005, 5);
      issue("inj_lo", FN_MFLO, '0, '0);
      issue("inj_hi", FN_MFHI, '0, '0);

      // reset at busy cycle 10 of a DIVU
      start = 1'b1; Signal = FN_DIVU; dataA = 32'd1000; dataB = 32'd3;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 10) begin
         n++;
         if (n < 10) @(negedge clk);
      end
      check("rstrun_reached", W'(n), W'(10));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_hi = '0; model_lo = '0; model_dout = '0;
      check("rstrun_busy", W'(busy), W'(0));
      check("rstrun_done", W'(done), W'(0));
      check("rstrun_dout", dataOut, '0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) n++;
      end
      check("rstrun_no_done", W'(n), W'(0));
      issue("rstrun_hi", FN_MFHI, '0, '0);
      issue("rstrun_lo", FN_MFLO, '0, '0);

      // reset together with start
      issue("pre_rs", FN_OR, 32'h0F, 32'hF0);
      rst = 1'b1; start = 1'b1; Signal = FN_ADD; dataA = 32'd9; dataB = 32'd9;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      model_dout = '0;
      check("rs_done", W'(done), W'(0));
      check("rs_busy", W'(busy), W'(0));
      check("rs_dout", dataOut, '0);
      idle_check("rs");
      check("rs_dout2", dataOut, '0);

      // randomized single-cycle ops (back-to-back) and multi-cycle ops
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
         issue("rnd_single", fn_tab[$urandom_range(0, 9)], ra, rb);
         if ($urandom_range(0, 3) == 0) idle_check("rnd_single");
      end
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300)) : $urandom;
         run_md("rnd_md", (i % 2 == 0) ? FN_MULTU : FN_DIVU, ra, rb, 0);
         issue("rnd_md_hi", FN_MFHI, '0, '0);
         issue("rnd_md_lo", FN_MFLO, '0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle ALU for the pipelined CPU's EX stage, decoding the same 6-bit MIPS funct field as the combinational ALU. Single-cycle ops are AND, OR, ADD, SUB, SLT and SRL. Iterative ops are MULTU and DIVU, which write internal HI/LO registers, read back via MFHI/MFLO. A start/busy/done handshake lets the pipeline stall on long ops.

## Interface
- WIDTH, 32, datapath width; ≥4 and a power of two.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue strobe; sampled only when busy=0.
- Signal  input  6  MIPS funct code of the issued op.
- dataA  input  WIDTH  operand A (rs); sampled with start.
- dataB  input  WIDTH  operand B (rt); shift amount is dataB[log2(WIDTH)-1:0].
- dataOut  output  WIDTH  registered result; holds until the next done.
- busy  output  1  high while MULTU/DIVU iterate.
- done  output  1  one-cycle pulse when dataOut or HI/LO is updated.

## Operation
- Funct codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010.
- ADD and SUB are modulo 2^WIDTH with no overflow trap.
- SLT is a signed two's-complement compare; the result is zero-extended 1 or 0.
- SRL is a logical right shift of dataA.
- Any other funct completes as a single-cycle op with dataOut=0.
- MULTU is an unsigned shift-add, one bit per cycle. The 2·WIDTH product goes to {HI,LO}. dataOut is unchanged.
- DIVU is unsigned restoring division, one bit per cycle. LO=quotient, HI=remainder. dataOut is unchanged.
- Divide by zero needs no special-casing; the algorithm yields LO=all-ones and HI=dataA.
- FSM:
  - IDLE: start with a single-cycle op stays in IDLE and registers its result. start with MULTU or DIVU loads operands, clears the counter, and goes to RUN.
  - RUN: counter increments each cycle. At count WIDTH-1 it writes HI/LO, pulses done, and returns to IDLE.
- start while busy=1 is ignored; no queueing.
- Reset: dataOut=0, HI=0, LO=0, busy=0, done=0, state=IDLE.
  - Reset mid-RUN aborts the op; no done and no HI/LO write.
  - rst wins over a simultaneous start.

## Timing
- Single-cycle op, start at edge t: dataOut valid and done=1 in cycle t+1. busy stays 0.
- MULTU/DIVU, start at edge t:
  - busy=1 in cycles t+1 … t+WIDTH.
  - HI/LO updated and done=1 in cycle t+WIDTH+1, with busy=0 in that cycle.
  - Total latency is WIDTH+1 cycles.
- Back-to-back issue:
  - A new start is accepted in any cycle with busy=0, including the done cycle.
  - MFHI issued in the done cycle of a MULTU returns the new HI one cycle later.
- done is never high for two consecutive cycles from the same op. Consecutive single-cycle issues give consecutive done pulses.

## Structure
- Shared package alu_pkg holds:
  - funct-code localparams (shared with the decoder and the combinational ALU);
  - FSM state encoding IDLE/RUN;
  - is_multicycle(funct) helper.
- Sub-module muldiv_iter(WIDTH) holds:
  - the accumulator/remainder, multiplicand/divisor and iteration counter;
  - inputs: load, op_is_div, operands;
  - outputs: hi, lo, last.
- The top level holds the FSM, the single-cycle datapath, HI/LO, and the output registers.

## Test plan
All values at WIDTH=32.
1. ADD 0x7FFFFFFF+0x00000001 → dataOut 0x80000000 one cycle later, done one cycle. SUB 5−7 → 0xFFFFFFFE. AND/OR of 0xF0F0F0F0 and 0xFF00FF00 → 0xF000F000 and 0xFFF0FFF0.
2. SLT 0xFFFFFFFF vs 0x00000001 → 1; reversed → 0. SRL 0x80000000 by 31 → 0x00000001. Unknown funct 111111 → 0 with done.
3. MULTU 0xFFFFFFFF×0xFFFFFFFF → busy for exactly 32 cycles, done at cycle 33. MFHI → 0xFFFFFFFE, MFLO → 0x00000001. dataOut unchanged through the op.
4. DIVU 100/7 → MFLO 14, MFHI 2. DIVU 0x12345678/0 → MFLO 0xFFFFFFFF, MFHI 0x12345678.
5. start with ADD at cycle 5 of a busy MULTU → ignored; dataOut and the MULTU result are unaffected. MFLO issued in the MULTU done cycle → new LO.
6. rst at cycle 10 of a DIVU → busy=0 next cycle, no done pulse, HI=LO=0, dataOut=0. rst together with start → op not accepted.
